// File: rtl/dcache_ctrl.sv
// MEM-stage data cache controller: direct-mapped, one word per line, write-through,
// no-write-allocate, in front of a byte-wide RAM port with one-cycle read latency.
module dcache_ctrl #(
    parameter int INDEX_W    = 6,
    parameter int RAM_ADDR_W = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_i,
    input  logic                  we_i,
    input  logic [3:0]            sel_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           data_i,
    output logic [31:0]           data_o,
    output logic                  stall_o,
    output logic [RAM_ADDR_W-1:0] ram_a_o,
    output logic                  ram_wr_o,
    output logic [7:0]            ram_dout_o,
    input  logic [7:0]            ram_din_i
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = RAM_ADDR_W - INDEX_W - 2;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q;
    logic [RAM_ADDR_W-3:0] base_q;
    logic [3:0]            sel_q, sel_rem;
    logic [31:0]           data_q, fill_q;
    logic                  load_q;
    logic [RAM_ADDR_W-1:0] ram_a_q;
    logic [7:0]            dout_q;
    logic [1:0]            lane, bidx;

    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_arr  [LINES];
    logic [31:0]           data_arr [LINES];

    logic [INDEX_W-1:0]    idx, fidx;
    logic [TAG_W-1:0]      tg, ftag;
    logic                  hit;

    logic unused_addr;
    assign unused_addr = ^{addr_i[31:RAM_ADDR_W], addr_i[1:0]};

    assign idx  = addr_i[INDEX_W+1:2];
    assign tg   = addr_i[RAM_ADDR_W-1:INDEX_W+2];
    assign hit  = valid_q[idx] && (tag_arr[idx] == tg);
    assign fidx = base_q[INDEX_W-1:0];
    assign ftag = base_q[RAM_ADDR_W-3:INDEX_W];
    // Byte captured this cycle was addressed last cycle, hence cnt-1 (cnt=4 wraps to lane 3).
    assign bidx = cnt_q[1:0] - 2'd1;

    // Lowest remaining selected lane is written next.
    always_comb begin
        lane = 2'd0;
        for (int k = 3; k >= 0; k--)
            if (sel_q[k]) lane = 2'(k);
        sel_rem = sel_q & ~(4'b0001 << lane);
    end

    always_comb begin
        state_d    = state_q;
        stall_o    = 1'b0;
        ram_wr_o   = 1'b0;
        ram_a_o    = ram_a_q;
        ram_dout_o = dout_q;
        data_o     = 32'd0;
        case (state_q)
            IDLE: if (ce_i) begin
                if (we_i) begin
                    stall_o = 1'b1;
                    state_d = (sel_i != 4'd0) ? WRITE : DONE;
                end else if (hit) begin
                    data_o = data_arr[idx];
                end else begin
                    stall_o = 1'b1;
                    ram_a_o = {addr_i[RAM_ADDR_W-1:2], 2'b00};
                    state_d = READ;
                end
            end
            READ: begin
                stall_o = 1'b1;
                if (cnt_q == 3'd4) state_d = DONE;
                else               ram_a_o = {base_q, cnt_q[1:0]};
            end
            WRITE: begin
                stall_o    = 1'b1;
                ram_wr_o   = 1'b1;
                ram_a_o    = {base_q, lane};
                ram_dout_o = data_q[{lane, 3'b000} +: 8];
                if (sel_rem == 4'd0) state_d = DONE;
            end
            DONE: begin
                if (load_q) data_o = fill_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            base_q  <= '0;
            sel_q   <= 4'd0;
            data_q  <= 32'd0;
            fill_q  <= 32'd0;
            load_q  <= 1'b0;
            ram_a_q <= '0;
            dout_q  <= 8'd0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            ram_a_q <= ram_a_o;
            dout_q  <= ram_dout_o;
            case (state_q)
                IDLE: if (ce_i) begin
                    base_q <= addr_i[RAM_ADDR_W-1:2];
                    sel_q  <= sel_i;
                    data_q <= data_i;
                    load_q <= ~we_i;
                    cnt_q  <= 3'd1;
                end
                READ: begin
                    fill_q[{bidx, 3'b000} +: 8] <= ram_din_i;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd4) valid_q[fidx] <= 1'b1;
                end
                WRITE: sel_q <= sel_rem;
                default: ;
            endcase
        end
    end

    // Tag/data storage needs no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && ce_i && we_i && hit) begin
            for (int k = 0; k < 4; k++)
                if (sel_i[k]) data_arr[idx][k*8 +: 8] <= data_i[k*8 +: 8];
        end
        if (state_q == READ && cnt_q == 3'd4) begin
            tag_arr[fidx]  <= ftag;
            data_arr[fidx] <= {ram_din_i, fill_q[23:0]};
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a byte-wide RAM model (one-cycle read latency).
module tb_dcache_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        ce_i = 1'b0, we_i = 1'b0;
    logic [3:0]  sel_i = 4'd0;
    logic [31:0] addr_i = 32'd0, data_i = 32'd0;
    logic [31:0] data_o;
    logic        stall_o, ram_wr_o;
    logic [16:0] ram_a_o;
    logic [7:0]  ram_dout_o, ram_din_i;

    logic [7:0]  mem [0:(1<<17)-1];
    logic        pl_we = 1'b0;
    logic [16:0] pl_a = 17'd0;
    logic [7:0]  pl_d = 8'd0;

    int n_cmp = 0, n_err = 0;

    dcache_ctrl #(.INDEX_W(6), .RAM_ADDR_W(17)) dut (
        .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .sel_i(sel_i),
        .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .stall_o(stall_o),
        .ram_a_o(ram_a_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o),
        .ram_din_i(ram_din_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_we)         mem[pl_a]    <= pl_d;
        else if (ram_wr_o) mem[ram_a_o] <= ram_dout_o;
        ram_din_i <= mem[ram_a_o];
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic preload(input logic [16:0] a, input logic [7:0] d);
        pl_a = a; pl_d = d; pl_we = 1'b1;
        tick();
        pl_we = 1'b0;
    endtask

    // Issues one load and reports the stalled cycle count and the word seen when stall drops.
    task automatic run_load(input logic [31:0] a, output int stalls, output logic [31:0] word);
        tick();
        ce_i = 1'b1; we_i = 1'b0; sel_i = 4'hF; addr_i = a;
        stalls = 0;
        #1;
        while (stall_o === 1'b1 && stalls < 20) begin
            stalls++;
            tick(); #1;
        end
        word = data_o;
        ce_i = 1'b0;
    endtask

    task automatic run_store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                             output int stalls, output int wrs);
        tick();
        ce_i = 1'b1; we_i = 1'b1; sel_i = s; addr_i = a; data_i = d;
        stalls = 0; wrs = 0;
        #1;
        while (stall_o === 1'b1 && stalls < 20) begin
            stalls++;
            if (ram_wr_o) wrs++;
            tick(); #1;
        end
        if (ram_wr_o) wrs++;
        ce_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] b [16];
        logic [16:0] a [16];
        b = '{8'h11,8'h22,8'h33,8'h44, 8'h0A,8'h0B,8'h0C,8'h0D,
              8'h01,8'h02,8'h03,8'h04, 8'h12,8'h34,8'h56,8'h78};
        a = '{17'h104,17'h105,17'h106,17'h107, 17'h204,17'h205,17'h206,17'h207,
              17'h308,17'h309,17'h30A,17'h30B, 17'h044,17'h045,17'h046,17'h047};
        rst = 1'b1;
        for (int i = 0; i < 16; i++) preload(a[i], b[i]);
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (stall_o !== 1'b0)     begin n_err++; $display("FAIL reset_stall got %b exp 0", stall_o); end
        n_cmp++; if (ram_wr_o !== 1'b0)    begin n_err++; $display("FAIL reset_wr got %b exp 0", ram_wr_o); end
        n_cmp++; if (ram_a_o !== 17'd0)    begin n_err++; $display("FAIL reset_addr got %h exp 0", ram_a_o); end
        n_cmp++; if (ram_dout_o !== 8'd0)  begin n_err++; $display("FAIL reset_dout got %h exp 0", ram_dout_o); end
        n_cmp++; if (data_o !== 32'd0)     begin n_err++; $display("FAIL reset_data got %h exp 0", data_o); end
        tick(); #1;
        n_cmp++; if (stall_o !== 1'b0 || data_o !== 32'd0)
            begin n_err++; $display("FAIL idle_noce got stall=%b data=%h exp 0/0", stall_o, data_o); end
    endtask

    task automatic test_load_miss_hit();
        logic [16:0] ea;
        tick();
        ce_i = 1'b1; we_i = 1'b0; sel_i = 4'h1; addr_i = 32'h104;
        #1;
        n_cmp++; if (stall_o !== 1'b1 || ram_a_o !== 17'h104)
            begin n_err++; $display("FAIL miss_t0 got stall=%b a=%h exp 1/104", stall_o, ram_a_o); end
        for (int i = 1; i <= 4; i++) begin
            tick(); #1;
            ea = (i < 4) ? 17'(32'h104 + i) : 17'h107;
            n_cmp++; if (stall_o !== 1'b1 || ram_a_o !== ea)
                begin n_err++; $display("FAIL miss_read%0d got stall=%b a=%h exp 1/%h", i, stall_o, ram_a_o, ea); end
        end
        tick(); #1;
        n_cmp++; if (stall_o !== 1'b0 || data_o !== 32'h44332211)
            begin n_err++; $display("FAIL miss_done got stall=%b data=%h exp 0/44332211", stall_o, data_o); end
        tick(); #1;
        n_cmp++; if (stall_o !== 1'b0 || data_o !== 32'h44332211)
            begin n_err++; $display("FAIL reload_hit got stall=%b data=%h exp 0/44332211", stall_o, data_o); end
        ce_i = 1'b0;
    endtask

    task automatic test_store_miss();
        int st; logic [31:0] w;
        tick();
        ce_i = 1'b1; we_i = 1'b1; sel_i = 4'b0100; addr_i = 32'h202; data_i = 32'hABABABAB;
        #1;
        n_cmp++; if (stall_o !== 1'b1 || ram_wr_o !== 1'b0)
            begin n_err++; $display("FAIL stm_t0 got stall=%b wr=%b exp 1/0", stall_o, ram_wr_o); end
        tick(); #1;
        n_cmp++; if (stall_o !== 1'b1 || ram_wr_o !== 1'b1 || ram_a_o !== 17'h202 || ram_dout_o !== 8'hAB)
            begin n_err++; $display("FAIL stm_write got stall=%b wr=%b a=%h d=%h exp 1/1/202/ab",
                                    stall_o, ram_wr_o, ram_a_o, ram_dout_o); end
        tick(); #1;
        n_cmp++; if (stall_o !== 1'b0 || ram_wr_o !== 1'b0)
            begin n_err++; $display("FAIL stm_done got stall=%b wr=%b exp 0/0", stall_o, ram_wr_o); end
        ce_i = 1'b0;
        n_cmp++; if (mem[17'h202] !== 8'hAB) begin n_err++; $display("FAIL stm_mem got %h exp ab", mem[17'h202]); end
        run_load(32'h200, st, w);
        n_cmp++; if (st !== 5 || w !== 32'h00AB0000)
            begin n_err++; $display("FAIL stm_noalloc got stalls=%0d data=%h exp 5/00ab0000", st, w); end
    endtask

    task automatic test_store_hit();
        int st; logic [31:0] w;
        tick();
        ce_i = 1'b1; we_i = 1'b1; sel_i = 4'b1100; addr_i = 32'h106; data_i = 32'hBEEFBEEF;
        #1;
        n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL sth_t0 got stall=%b exp 1", stall_o); end
        tick(); #1;
        n_cmp++; if (ram_wr_o !== 1'b1 || ram_a_o !== 17'h106 || ram_dout_o !== 8'hEF)
            begin n_err++; $display("FAIL sth_w0 got wr=%b a=%h d=%h exp 1/106/ef", ram_wr_o, ram_a_o, ram_dout_o); end
        tick(); #1;
        n_cmp++; if (ram_wr_o !== 1'b1 || ram_a_o !== 17'h107 || ram_dout_o !== 8'hBE)
            begin n_err++; $display("FAIL sth_w1 got wr=%b a=%h d=%h exp 1/107/be", ram_wr_o, ram_a_o, ram_dout_o); end
        tick(); #1;
        n_cmp++; if (stall_o !== 1'b0 || ram_wr_o !== 1'b0)
            begin n_err++; $display("FAIL sth_done got stall=%b wr=%b exp 0/0", stall_o, ram_wr_o); end
        ce_i = 1'b0;
        run_load(32'h104, st, w);
        n_cmp++; if (st !== 0 || w !== 32'hBEEF2211)
            begin n_err++; $display("FAIL sth_hit got stalls=%0d data=%h exp 0/beef2211", st, w); end
        n_cmp++; if (mem[17'h106] !== 8'hEF || mem[17'h107] !== 8'hBE)
            begin n_err++; $display("FAIL sth_mem got %h %h exp ef be", mem[17'h106], mem[17'h107]); end
    endtask

    task automatic test_alias();
        int st; logic [31:0] w;
        run_load(32'h104, st, w);
        n_cmp++; if (st !== 0) begin n_err++; $display("FAIL alias_pre got stalls=%0d exp 0", st); end
        run_load(32'h204, st, w);
        n_cmp++; if (st !== 5 || w !== 32'h0D0C0B0A)
            begin n_err++; $display("FAIL alias_b got stalls=%0d data=%h exp 5/0d0c0b0a", st, w); end
        run_load(32'h104, st, w);
        n_cmp++; if (st !== 5 || w !== 32'hBEEF2211)
            begin n_err++; $display("FAIL alias_a got stalls=%0d data=%h exp 5/beef2211", st, w); end
    endtask

    task automatic test_reset_mid();
        int st; logic [31:0] w;
        tick();
        ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h308;
        tick(); tick(); #1;
        n_cmp++; if (stall_o !== 1'b1 || ram_a_o !== 17'h30A)
            begin n_err++; $display("FAIL rmid_cnt2 got stall=%b a=%h exp 1/30a", stall_o, ram_a_o); end
        rst = 1'b1; ce_i = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (stall_o !== 1'b0 || ram_a_o !== 17'd0 || ram_wr_o !== 1'b0)
            begin n_err++; $display("FAIL rmid_idle got stall=%b a=%h wr=%b exp 0/0/0", stall_o, ram_a_o, ram_wr_o); end
        run_load(32'h308, st, w);
        n_cmp++; if (st !== 5 || w !== 32'h04030201)
            begin n_err++; $display("FAIL rmid_refill got stalls=%0d data=%h exp 5/04030201", st, w); end
        run_load(32'h104, st, w);
        n_cmp++; if (st !== 5 || w !== 32'hBEEF2211)
            begin n_err++; $display("FAIL rmid_cleared got stalls=%0d data=%h exp 5/beef2211", st, w); end
    endtask

    task automatic test_sel_zero();
        int st, wrs;
        run_store(32'h10, 4'b0000, 32'h12345678, st, wrs);
        n_cmp++; if (st !== 1 || wrs !== 0)
            begin n_err++; $display("FAIL sel0 got stalls=%0d wr=%0d exp 1/0", st, wrs); end
    endtask

    task automatic test_back_to_back();
        logic [8:0]  pat;
        logic [31:0] w;
        logic [16:0] a3;
        int wrs;
        pat = '0; wrs = 0; w = '0; a3 = '0;
        tick();
        ce_i = 1'b1; we_i = 1'b1; sel_i = 4'b0001; addr_i = 32'h40; data_i = 32'h5A5A5A5A;
        for (int c = 0; c < 9; c++) begin
            #1;
            pat[c] = stall_o;
            if (ram_wr_o) wrs++;
            if (c == 3) a3 = ram_a_o;
            if (c == 8) w = data_o;
            if (c == 2) begin we_i = 1'b0; addr_i = 32'h44; end
            if (c < 8) tick();
        end
        ce_i = 1'b0;
        n_cmp++; if (pat !== 9'b011111011)
            begin n_err++; $display("FAIL b2b_stall got %b exp 011111011", pat); end
        n_cmp++; if (wrs !== 1) begin n_err++; $display("FAIL b2b_wr got %0d exp 1", wrs); end
        n_cmp++; if (a3 !== 17'h44) begin n_err++; $display("FAIL b2b_addr got %h exp 44", a3); end
        n_cmp++; if (w !== 32'h78563412) begin n_err++; $display("FAIL b2b_data got %h exp 78563412", w); end
        n_cmp++; if (mem[17'h40] !== 8'h5A) begin n_err++; $display("FAIL b2b_mem got %h exp 5a", mem[17'h40]); end
    endtask

    initial begin
        test_reset();
        test_load_miss_hit();
        test_store_miss();
        test_store_hit();
        test_alias();
        test_reset_mid();
        test_sel_zero();
        test_back_to_back();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
